// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
//   state_e : controller state encoding
//   OP_ADD  : op value selecting a + b
//   OP_SUB  : op value selecting a - b (b inverted, carry seeded with 1)
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Request/response bundle between a command source and serial_addsub_ctrl.
//   start    : request, sampled only while the controller is idle
//   op       : 0 = add, 1 = subtract, latched with start
//   a, b     : operands (a is the minuend), latched with start
//   busy     : operation in progress
//   done     : one-cycle pulse, result/cout/overflow valid
//   result   : sum or difference, two's complement
//   cout     : final carry (for subtract, 1 = no borrow)
//   overflow : signed overflow of the operation
interface serial_addsub_ctrl_if #(
   parameter int WIDTH = 8
) ();

   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             overflow;

   modport master (
      output start, op, a, b,
      input  busy, done, result, cout, overflow
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, cout, overflow
   );

endinterface

// File: rtl/serial_addsub_ctrl_cell.sv
// Shared 1-bit add/subtract cell.
//   in0, in1 : operand bits
//   cin      : carry in
//   addsub   : 1 inverts in1 (subtract)
//   sum      : in0 ^ (in1 ^ addsub) ^ cin
//   cout     : majority(in0, in1 ^ addsub, cin)
module addsub_cell (
   input  logic in0,
   input  logic in1,
   input  logic cin,
   input  logic addsub,
   output logic sum,
   output logic cout
);

   logic in1_x;

   assign in1_x = in1 ^ addsub;
   assign sum   = in0 ^ in1_x ^ cin;
   assign cout  = (in0 & in1_x) | (in0 & cin) | (in1_x & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor controller: walks one addsub_cell over WIDTH
// cycles, LSB first, and reports result, carry and signed overflow.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_addsub_ctrl_if slave (start/op/a/b in, busy/done/result/cout/overflow out)
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one bit per cycle, WIDTH cycles
// DONE  | single cycle; result and flags committed to the output registers
//
// The outputs are registered views of the state, so busy/done trail the
// state by one cycle: done is seen the cycle after DONE, while busy covers it.
module serial_addsub_ctrl
   import addsub_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input logic                clk,
   input logic                rst_n,
   serial_addsub_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] res_sr_q, res_sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             op_q, op_d;
   logic             carry_q, carry_d;
   logic             cin_msb_q, cin_msb_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             cell_sum;
   logic             cell_cout;

   addsub_cell u_cell (
      .in0    (a_sr_q[0]),
      .in1    (b_sr_q[0]),
      .cin    (carry_q),
      .addsub (op_q),
      .sum    (cell_sum),
      .cout   (cell_cout)
   );

   always_comb begin
      state_d   = state_q;
      a_sr_d    = a_sr_q;
      b_sr_d    = b_sr_q;
      res_sr_d  = res_sr_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      carry_d   = carry_q;
      cin_msb_d = cin_msb_q;
      result_d  = result_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;
      busy_d    = (state_q != IDLE);
      done_d    = (state_q == DONE);

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_sr_d  = bus.a;
               b_sr_d  = bus.b;
               op_d    = bus.op;
               // Subtract is a + ~b + 1: the +1 rides in on the carry.
               carry_d = (bus.op == OP_SUB);
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_sr_d = {cell_sum, res_sr_q[WIDTH-1:1]};
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            carry_d  = cell_cout;
            if (cnt_q == CNT_LAST) begin
               // Carry into the sign bit, needed for signed overflow.
               cin_msb_d = carry_q;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            result_d = res_sr_q;
            cout_d   = carry_q;
            ovf_d    = cin_msb_q ^ carry_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_sr_q    <= '0;
         b_sr_q    <= '0;
         res_sr_q  <= '0;
         cnt_q     <= '0;
         op_q      <= 1'b0;
         carry_q   <= 1'b0;
         cin_msb_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
         cout_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_sr_q    <= a_sr_d;
         b_sr_q    <= b_sr_d;
         res_sr_q  <= res_sr_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         carry_q   <= carry_d;
         cin_msb_q <= cin_msb_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         result_q  <= result_d;
         cout_q    <= cout_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.result   = result_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl (WIDTH = 8).
module tb_serial_addsub_ctrl;
   import addsub_pkg::*;

   localparam int WIDTH = 8;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   serial_addsub_ctrl_if #(.WIDTH(WIDTH)) bus ();

   serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   task automatic model(input logic op_i, input logic [7:0] a_i, input logic [7:0] b_i,
                        output logic [7:0] res_o, output logic cout_o, output logic ovf_o);
      int ua, ub, ur, sa, sb, sr;
      ua = int'(a_i);
      ub = int'(b_i);
      sa = (ua > 127) ? ua - 256 : ua;
      sb = (ub > 127) ? ub - 256 : ub;
      if (op_i == OP_SUB) begin
         ur     = ua - ub;
         sr     = sa - sb;
         cout_o = (ua >= ub);
      end else begin
         ur     = ua + ub;
         sr     = sa + sb;
         cout_o = (ur > 255);
      end
      res_o = ur[7:0];
      ovf_o = (sr > 127) || (sr < -128);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called #1 after a rising edge with the DUT idle.
   task automatic do_op(input logic op_i, input logic [7:0] a_i, input logic [7:0] b_i,
                        input string tag);
      logic [7:0] er;
      logic       ec, eo;
      int         lat;
      model(op_i, a_i, b_i, er, ec, eo);
      bus.start = 1'b1;
      bus.op    = op_i;
      bus.a     = a_i;
      bus.b     = b_i;
      tick();
      bus.start = 1'b0;
      bus.op    = 1'($urandom);
      bus.a     = 8'($urandom);
      bus.b     = 8'($urandom);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!bus.done && lat < 20);
      chk({tag, " latency"}, lat, 9);
      chk({tag, " result"}, bus.result, er);
      chk({tag, " cout"}, bus.cout, ec);
      chk({tag, " overflow"}, bus.overflow, eo);
      chk({tag, " busy_at_done"}, bus.busy, 1);
      tick();
      chk({tag, " done_one_cycle"}, bus.done, 0);
      chk({tag, " busy_after"}, bus.busy, 0);
      chk({tag, " result_hold"}, bus.result, er);
   endtask

   initial begin
      int n_done, prev, cyc;
      logic       rop;
      logic [7:0] ra, rb;

      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op    = OP_ADD;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) tick();
      chk("rst busy", bus.busy, 0);
      chk("rst done", bus.done, 0);
      chk("rst result", bus.result, 0);
      chk("rst cout", bus.cout, 0);
      chk("rst overflow", bus.overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Directed cases
      do_op(OP_ADD, 8'h5A, 8'h33, "add_5a_33");
      do_op(OP_SUB, 8'h10, 8'h01, "sub_10_01");
      do_op(OP_SUB, 8'h00, 8'h01, "sub_00_01");
      do_op(OP_SUB, 8'h80, 8'h01, "sub_80_01");
      do_op(OP_ADD, 8'hFF, 8'h01, "add_ff_01");
      do_op(OP_ADD, 8'h7F, 8'h01, "add_7f_01");

      // Start pulses while busy are ignored
      bus.start = 1'b1; bus.op = OP_ADD; bus.a = 8'h01; bus.b = 8'h01;
      tick();
      bus.start = 1'b0;
      repeat (3) tick();
      bus.start = 1'b1; bus.op = OP_SUB; bus.a = 8'hAA; bus.b = 8'h55;
      tick();
      bus.start = 1'b0;
      repeat (4) tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("ign done", bus.done, 1);
      chk("ign result", bus.result, 8'h02);
      chk("ign busy_at_done", bus.busy, 1);
      tick();
      chk("ign busy_after", bus.busy, 0);
      n_done = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bus.done || bus.busy) n_done++;
      end
      chk("ign no_relaunch", n_done, 0);

      // Async reset mid-RUN
      bus.start = 1'b1; bus.op = OP_ADD; bus.a = 8'h5A; bus.b = 8'h33;
      tick();
      bus.start = 1'b0;
      repeat (3) tick();
      chk("pre_rst busy", bus.busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async busy", bus.busy, 0);
      chk("async done", bus.done, 0);
      chk("async result", bus.result, 0);
      chk("async cout", bus.cout, 0);
      chk("async overflow", bus.overflow, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bus.done) n_done++;
      end
      chk("rst no_done", n_done, 0);
      do_op(OP_ADD, 8'h03, 8'h04, "after_rst");

      // start held high: one accept per idle visit
      bus.start = 1'b1; bus.op = OP_ADD; bus.a = 8'h01; bus.b = 8'h02;
      n_done = 0;
      prev   = -1;
      for (cyc = 1; cyc <= 50; cyc++) begin
         tick();
         if (bus.done) begin
            n_done++;
            chk("b2b result", bus.result, 8'h03);
            if (prev < 0) chk("b2b first", cyc, 10);
            else          chk("b2b period", cyc - prev, 10);
            prev = cyc;
         end
      end
      bus.start = 1'b0;
      chk("b2b count", n_done, 5);
      tick();

      // Random sweep
      for (int i = 0; i < 200; i++) begin
         rop = 1'($urandom);
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         do_op(rop, ra, rb, $sformatf("rnd%0d", i));
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
